// File: rtl/iigs_timing_pkg.sv
// Slow-bus video timing constants shared by clock_divider, ph0_video_timing and the video blocks.
package iigs_timing_pkg;

  localparam int unsigned H_TOTAL   = 65;
  localparam int unsigned V_NTSC    = 262;
  localparam int unsigned V_PAL     = 312;
  localparam int unsigned HBL_END   = 25;
  localparam int unsigned VBL_START = 192;

  localparam int unsigned H_W = 7;
  localparam int unsigned V_W = 9;

endpackage

// File: rtl/wrap_counter.sv
// Width-parameterised up-counter with increment enable, runtime modulus and a wrap strobe.
module wrap_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_last;

  // >= rather than == so a modulus that shrinks below the count still wraps cleanly.
  assign at_last = (count_q >= (modulus - W'(1)));
  assign wrap    = inc & at_last;
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = at_last ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ph0_video_timing.sv
// Counts PH0 cycles into scanlines and frames; requests the long 65th cycle and exports beam state.
module ph0_video_timing
  import iigs_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL   = iigs_timing_pkg::H_TOTAL,
  parameter int unsigned V_NTSC    = iigs_timing_pkg::V_NTSC,
  parameter int unsigned V_PAL     = iigs_timing_pkg::V_PAL,
  parameter int unsigned HBL_END   = iigs_timing_pkg::HBL_END,
  parameter int unsigned VBL_START = iigs_timing_pkg::VBL_START
) (
  input  logic           clk_14M,
  input  logic           reset_n,
  input  logic           ph0_en,
  input  logic           ph0_state,
  input  logic           pal,
  output logic           stretch,
  output logic [H_W-1:0] h_count,
  output logic [V_W-1:0] v_count,
  output logic           hbl,
  output logic           vbl,
  output logic           line_start,
  output logic           frame_start
);

  logic           boundary;
  logic           h_wrap;
  logic           v_wrap;
  logic [V_W-1:0] v_modulus;

  logic frame_len_q, frame_len_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // A new PH0 cycle begins when the strobe arrives while PH0 is still high.
  assign boundary  = ph0_en & ph0_state;
  assign v_modulus = frame_len_q ? V_W'(V_PAL) : V_W'(V_NTSC);

  wrap_counter #(
    .W (H_W)
  ) u_h_counter (
    .clk     (clk_14M),
    .reset_n (reset_n),
    .inc     (boundary),
    .modulus (H_W'(H_TOTAL)),
    .count   (h_count),
    .wrap    (h_wrap)
  );

  wrap_counter #(
    .W (V_W)
  ) u_v_counter (
    .clk     (clk_14M),
    .reset_n (reset_n),
    .inc     (h_wrap),
    .modulus (v_modulus),
    .count   (v_count),
    .wrap    (v_wrap)
  );

  always_comb begin
    frame_len_d   = frame_len_q;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    // Frame length only changes at a frame boundary so a frame is never cut short.
    if (v_wrap) begin
      frame_len_d = pal;
    end
  end

  always_ff @(posedge clk_14M) begin
    if (!reset_n) begin
      frame_len_q   <= pal;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_len_q   <= frame_len_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign stretch     = (h_count == H_W'(H_TOTAL - 1));
  assign hbl         = (h_count < H_W'(HBL_END));
  assign vbl         = (v_count >= V_W'(VBL_START));
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ph0_video_timing.sv
// Directed bench for ph0_video_timing with a small beam-position model for long runs.
module tb_ph0_video_timing;

  logic       clk_14M = 1'b0;
  logic       reset_n;
  logic       ph0_en;
  logic       ph0_state;
  logic       pal;
  logic       stretch;
  logic [6:0] h_count;
  logic [8:0] v_count;
  logic       hbl;
  logic       vbl;
  logic       line_start;
  logic       frame_start;

  ph0_video_timing dut (
    .clk_14M     (clk_14M),
    .reset_n     (reset_n),
    .ph0_en      (ph0_en),
    .ph0_state   (ph0_state),
    .pal         (pal),
    .stretch     (stretch),
    .h_count     (h_count),
    .v_count     (v_count),
    .hbl         (hbl),
    .vbl         (vbl),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk_14M = ~clk_14M;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   hm, vm;
  bit   lenm;
  int   bad, ls_cnt, fs_cnt, st_rise, vbl_lines;
  logic prev_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    bad = 0; ls_cnt = 0; fs_cnt = 0; st_rise = 0; vbl_lines = 0;
  endtask

  // Compare every output against the model; pulses are only legal right after a boundary.
  task automatic sample(input bit pulse_ok);
    logic exp_ls, exp_fs;
    exp_ls = pulse_ok && (hm == 0);
    exp_fs = exp_ls && (vm == 0);
    if (h_count !== 7'(hm) || v_count !== 9'(vm) || stretch !== 1'(hm == 64) ||
        hbl !== 1'(hm < 25) || vbl !== 1'(vm >= 192) || line_start !== exp_ls ||
        frame_start !== exp_fs)
      bad++;
    if (line_start === 1'b1) begin
      ls_cnt++;
      if (vbl === 1'b1) vbl_lines++;
    end
    if (frame_start === 1'b1) fs_cnt++;
    if (stretch === 1'b1 && prev_st !== 1'b1) st_rise++;
    prev_st = stretch;
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ph0_en = 1'b1; ph0_state = 1'b1;
      @(posedge clk_14M); #1;
      ph0_en = 1'b0; ph0_state = 1'b0;
      if (hm == 64) begin
        hm = 0;
        if (vm >= (lenm ? 312 : 262) - 1) begin
          vm   = 0;
          lenm = pal;
        end else begin
          vm++;
        end
      end else begin
        hm++;
      end
      sample(1'b1);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk_14M); #1;
        sample(1'b0);
      end
    end
  endtask

  initial begin
    int g;
    reset_n = 1'b0; ph0_en = 1'b0; ph0_state = 1'b0; pal = 1'b0;
    repeat (2) @(posedge clk_14M);
    #1;
    check("rst h_count", 32'(h_count), 0);
    check("rst v_count", 32'(v_count), 0);
    check("rst stretch", 32'(stretch), 0);
    check("rst hbl", 32'(hbl), 1);
    check("rst vbl", 32'(vbl), 0);
    check("rst line_start", 32'(line_start), 0);
    check("rst frame_start", 32'(frame_start), 0);
    reset_n = 1'b1;
    hm = 0; vm = 0; lenm = 1'b0; prev_st = 1'b0;

    // 64 boundaries reach the long cycle.
    clear_stats();
    for (int i = 1; i <= 64; i++) begin
      run(1, 1);
      if (i == 24) check("hbl at h24", 32'(hbl), 1);
      if (i == 25) check("hbl at h25", 32'(hbl), 0);
    end
    check("h after 64", 32'(h_count), 64);
    check("stretch at 64", 32'(stretch), 1);
    check("no line_start yet", 32'(ls_cnt), 0);
    check("model first line", 32'(bad), 0);

    // Boundary 65 wraps the line.
    run(1, 0);
    check("h wrap", 32'(h_count), 0);
    check("line_start pulse", 32'(line_start), 1);
    check("stretch fall", 32'(stretch), 0);
    check("v after line", 32'(v_count), 1);
    check("no frame_start", 32'(frame_start), 0);
    @(posedge clk_14M); #1;
    check("line_start one clk", 32'(line_start), 0);

    // Strobes while PH0 is low must not count.
    clear_stats();
    for (int i = 0; i < 50; i++) begin
      ph0_en = 1'b1; ph0_state = 1'b0;
      @(posedge clk_14M); #1;
      ph0_en = 1'b0;
      sample(1'b0);
    end
    check("ph0 low h", 32'(h_count), 0);
    check("ph0 low v", 32'(v_count), 1);
    check("ph0 low pulses", 32'(ls_cnt), 0);
    check("ph0 low model", 32'(bad), 0);

    // Complete the NTSC frame with back-to-back boundaries.
    clear_stats();
    run(261 * 65, 0);
    check("ntsc v wrap", 32'(v_count), 0);
    check("ntsc h wrap", 32'(h_count), 0);
    check("ntsc frame_start", 32'(frame_start), 1);
    check("ntsc line_start", 32'(line_start), 1);
    check("ntsc frame count", 32'(fs_cnt), 1);
    check("ntsc line count", 32'(ls_cnt), 261);
    check("ntsc vbl lines", 32'(vbl_lines), 70);
    check("ntsc model", 32'(bad), 0);

    // PAL selected mid-frame waits for the next wrap.
    clear_stats();
    run(100 * 65, 0);
    pal = 1'b1;
    run(162 * 65, 0);
    check("pal late v", 32'(v_count), 0);
    check("pal late fs", 32'(frame_start), 1);
    run(311 * 65, 0);
    check("pal v311", 32'(v_count), 311);
    check("pal vbl", 32'(vbl), 1);
    check("pal frames so far", 32'(fs_cnt), 1);
    run(65, 0);
    check("pal wrap v", 32'(v_count), 0);
    check("pal wrap fs", 32'(frame_start), 1);
    check("pal frames", 32'(fs_cnt), 2);
    check("pal model", 32'(bad), 0);

    // Mid-line reset coinciding with a boundary.
    run(150 * 65 + 30, 0);
    check("pre-reset h", 32'(h_count), 30);
    check("pre-reset v", 32'(v_count), 150);
    reset_n = 1'b0; pal = 1'b0; ph0_en = 1'b1; ph0_state = 1'b1;
    @(posedge clk_14M); #1;
    ph0_en = 1'b0; ph0_state = 1'b0; reset_n = 1'b1;
    check("mid rst h", 32'(h_count), 0);
    check("mid rst v", 32'(v_count), 0);
    check("mid rst stretch", 32'(stretch), 0);
    check("mid rst hbl", 32'(hbl), 1);
    check("mid rst vbl", 32'(vbl), 0);
    check("mid rst line_start", 32'(line_start), 0);
    check("mid rst frame_start", 32'(frame_start), 0);
    hm = 0; vm = 0; lenm = 1'b0; prev_st = 1'b0;
    clear_stats();
    run(1, 0);
    check("post rst h", 32'(h_count), 1);

    // Mixed fast/slow boundary spacing.
    clear_stats();
    for (int i = 0; i < 130; i++) begin
      case ($urandom_range(0, 2))
        0:       g = 13;
        1:       g = 15;
        default: g = 6;
      endcase
      run(1, g);
    end
    check("mixed stretch count", 32'(st_rise), 2);
    check("mixed line count", 32'(ls_cnt), 2);
    check("mixed model", 32'(bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
